// File: rtl/sha_block_384_serializer.sv
// Block-to-word serializer feeding the SHA-256 message expander, MS word first.
// Optional byte reversal of each output word: define SHA_SER_BSWAP_EN.
module sha_block_384_serializer #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 12,
  parameter int IDX_W   = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      flush,
  input  logic                      blk_valid,
  output logic                      blk_ready,
  input  logic [WORD_W*N_WORDS-1:0] block_in,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic [WORD_W-1:0]         word_out,
  output logic [IDX_W-1:0]          word_idx,
  output logic                      word_last,
  output logic                      busy
);

  localparam int BLK_W = WORD_W * N_WORDS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t             state;
  logic [BLK_W-1:0]   shreg;
  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  raw;
  logic               at_last;

  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      shreg <= '0;
      idx   <= '0;
    end else if (flush) begin
      state <= IDLE;
      shreg <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid) begin
            shreg <= block_in;
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (word_ready) begin
            // Clearing on the last beat keeps word_out at 0 while idle
            if (at_last) begin
              state <= IDLE;
              shreg <= '0;
              idx   <= '0;
            end else begin
              shreg <= shreg << WORD_W;
              idx   <= idx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign blk_ready  = (state == IDLE);
  assign word_valid = (state == SEND);
  assign busy       = (state == SEND);
  assign word_idx   = idx;
  assign word_last  = (state == SEND) && at_last;
  assign raw        = shreg[BLK_W-1 -: WORD_W];

`ifdef SHA_SER_BSWAP_EN
  always_comb begin
    word_out = raw;
    for (int b = 0; b < WORD_W / 8; b++) begin
      word_out[8*b +: 8] = raw[WORD_W-8-8*b +: 8];
    end
  end
`else
  assign word_out = raw;
`endif

endmodule

// File: tb/tb_sha_block_384_serializer.sv
// Directed self-checking bench for sha_block_384_serializer.
// Exercises streaming, stalls, back-to-back blocks, flush and async reset.
module tb_sha_block_384_serializer;

  logic         CLK;
  logic         RST;
  logic         flush;
  logic         blk_valid;
  logic         blk_ready;
  logic [383:0] block_in;
  logic         word_valid;
  logic         word_ready;
  logic [31:0]  word_out;
  logic [3:0]   word_idx;
  logic         word_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  sha_block_384_serializer dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .block_in  (block_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_out  (word_out),
    .word_idx  (word_idx),
    .word_last (word_last),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [383:0] mk(input logic [31:0] base);
    logic [383:0] b;
    b = '0;
    for (int k = 0; k < 12; k++) b[383-32*k -: 32] = base + 32'(k);
    return b;
  endfunction

  function automatic logic [31:0] ew(input logic [31:0] w);
`ifdef SHA_SER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] base,
                          input int k);
    chk({tag, "_valid"}, 32'(word_valid), 32'd1);
    chk({tag, "_out"}, word_out, ew(base + 32'(k)));
    chk({tag, "_idx"}, 32'(word_idx), 32'(k));
    chk({tag, "_last"}, 32'(word_last), 32'(k == 11));
    chk({tag, "_bready"}, 32'(blk_ready), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_bready"}, 32'(blk_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idx"}, 32'(word_idx), 32'd0);
    chk({tag, "_out"}, word_out, 32'd0);
    chk({tag, "_last"}, 32'(word_last), 32'd0);
  endtask

  initial begin
    int k;
    RST        = 1'b0;
    flush      = 1'b0;
    blk_valid  = 1'b0;
    word_ready = 1'b0;
    block_in   = '0;
    #12;
    chk_idle("reset");
    RST = 1'b1;
    tick();

    // 1: full-rate stream, word k = k
    block_in  = mk(32'd0);
    blk_valid = 1'b1;
    tick();
    blk_valid  = 1'b0;
    word_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk_word("t1", 32'd0, i);
      tick();
    end
    chk_idle("t1_end");

    // 2: ready toggling 1,0,1,0
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 12; c++) begin
      word_ready = (c % 2 == 0);
      chk_word("t2", 32'd0, k);
      tick();
      if (c % 2 == 0) k++;
    end
    chk("t2_beats", 32'(k), 32'd12);
    chk_idle("t2_end");

    // 3: back-to-back blocks, blk_valid held; second top word 11223344
    word_ready = 1'b1;
    block_in   = mk(32'hA0);
    blk_valid  = 1'b1;
    tick();
    block_in = mk(32'h11223344);
    for (int i = 0; i < 12; i++) begin
      chk_word("t3a", 32'hA0, i);
      tick();
    end
    chk("t3_gap_bready", 32'(blk_ready), 32'd1);
    chk("t3_gap_valid", 32'(word_valid), 32'd0);
    tick();
    blk_valid = 1'b0;
`ifdef SHA_SER_BSWAP_EN
    chk("t3_top_const", word_out, 32'h44332211);
`else
    chk("t3_top_const", word_out, 32'h11223344);
`endif
    for (int i = 0; i < 12; i++) begin
      chk_word("t3b", 32'h11223344, i);
      tick();
    end
    chk_idle("t3_end");

    // 4: flush after word 5 beat, then new block, then flush vs blk_valid
    block_in  = mk(32'h100);
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk_word("t4a", 32'h100, i);
      tick();
    end
    chk_word("t4a6", 32'h100, 6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_idle("t4_flush");
    block_in  = mk(32'h200);
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk_word("t4b", 32'h200, i);
      tick();
    end
    flush     = 1'b1;
    blk_valid = 1'b1;
    tick();
    flush     = 1'b0;
    blk_valid = 1'b0;
    chk_idle("t4_flush_prio");

    // 5: async reset at idx 7
    block_in  = mk(32'h300);
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk_word("t5", 32'h300, i);
      tick();
    end
    chk_word("t5_7", 32'h300, 7);
    #2;
    RST = 1'b0;
    #1;
    chk_idle("t5_rst");
    #2;
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("t5_after");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_block_384_serializer.md
Name: sha_block_384_serializer

Overview:
- Read-side companion to the 384-bit block store; the consumer end of that interface.
- Accepts one stored 384-bit block (12 x 32-bit words) over a valid/ready handshake.
- Streams the words most-significant first into the SHA-256 compact message expander, one word per accepted beat.
- Gives the expander W0..W11 in order, with index and last-word flags.

Parameters:
- WORD_W, 32: word width in bits.
- N_WORDS, 12: words per block. Block width = WORD_W*N_WORDS = 384. Legal range 2..16.
- IDX_W, 4: width of word_idx. Must satisfy 2^IDX_W >= N_WORDS.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- flush  in  1  synchronous abort, drops the block in flight
- blk_valid  in  1  block_in is valid
- blk_ready  out  1  serializer can accept a block
- block_in  in  384  block from the block store
- word_valid  out  1  word_out is valid
- word_ready  in  1  expander accepts word_out
- word_out  out  32  current word
- word_idx  out  IDX_W  index of current word, 0..N_WORDS-1
- word_last  out  1  current word is index N_WORDS-1
- busy  out  1  block in flight

Behaviour:
- Reset: RST is asynchronous, active-low; CLK is the clock. RST=0 forces:
  - state IDLE; shift register, index counter and word_out all 0
  - word_valid=0, word_last=0, busy=0, word_idx=0
  - blk_ready=1, because it is decoded from the IDLE state
- States: IDLE and SEND.
- IDLE:
  - blk_ready=1, word_valid=0, word_out=0.
  - On blk_valid=1 (handshake at the clock edge): capture block_in into the shift register, clear the index, go to SEND.
  - block_in is sampled only at that edge.
- SEND:
  - blk_ready=0, word_valid=1, busy=1.
  - word_out = shift register bits [383:352].
  - word_idx = index counter; word_last = (word_idx == N_WORDS-1).
- Beat on word_ready=1 in SEND:
  - shift left by WORD_W, zero-filling the LSBs; index increments.
  - If word_last=1, go to IDLE instead of shifting further.
- Stall: while word_valid=1 and word_ready=0, word_out, word_idx and word_last hold stable. Once raised, word_valid is never dropped before the handshake.
- Output order: word k = block_in[383-32k : 352-32k]. Word 0 is the top 32 bits.
- Latency and throughput:
  - first word is valid the cycle after the block handshake;
  - with word_ready held high, 12 words take 12 consecutive cycles;
  - one IDLE bubble follows, so minimum block period is 13 cycles.
- blk_ready depends only on state, never combinationally on word_ready.
- flush=1 at an edge:
  - highest priority over every other event;
  - goes to IDLE, clears the counter and shift register, and discards remaining words;
  - a simultaneous blk_valid in IDLE is not accepted;
  - a simultaneous word handshake is still counted by the consumer, but the serializer state is cleared.
- Reset mid-block: same effect as flush, applied asynchronously.
- The index counter never wraps past N_WORDS-1.
- blk_valid while in SEND is ignored (blk_ready=0). The upstream holds it.

Optional Feature:
- Macro: SHA_SER_BSWAP_EN.
- Defined: each output word is byte-reversed, so word_out = {w[7:0], w[15:8], w[23:16], w[31:24]}. Supports little-endian block sources. Applies to the word_out path only; index and handshakes are unchanged.
- Undefined: words are output unchanged, big-endian as in SHA-256.

Test Plan:
1. Reset, then block_in = 384'h00000000_00000001_..._0000000B (word k = k), blk_valid for one cycle, word_ready=1 throughout -> words 0..11 on 12 consecutive cycles; word_idx 0..11; word_last only on idx 11; blk_ready=1 on the cycle after the last beat.
2. Same block with word_ready toggling 1,0,1,0 -> each word held stable through its stall cycle; no word skipped or duplicated; 12 beats total.
3. blk_valid held high with two different back-to-back blocks -> second block accepted exactly one cycle after the first block's word 11 beat; first output of the second block equals its top word.
4. flush pulsed after the word 5 beat -> next cycle word_valid=0, blk_ready=1; a new block then starts at word_idx=0 with its own top word.
5. RST driven low mid-block (idx 7), asynchronously with respect to CLK -> all outputs go to reset values immediately; after release, no residual words appear.
6. With SHA_SER_BSWAP_EN defined, word 0 = 32'h11223344 -> word_out = 32'h44332211.
